// File: rtl/sobel_stream_pkg.sv
// Shared definitions for the streaming Sobel edge detector.
//   WORD_SIZE    : default pixel width for the greyscale pipeline
//   GRAD_GROWTH  : extra bits a Sobel gradient needs over the pixel width
//   sobel_mode_e : output selection for sobel_stream.mode
package sobel_stream_pkg;

    localparam int WORD_SIZE   = 8;
    localparam int GRAD_GROWTH = 3;

    typedef enum logic [1:0] {
        SOBEL_MAG    = 2'd0,  // |Gx| + |Gy|, saturated
        SOBEL_GX     = 2'd1,  // |Gx|, saturated
        SOBEL_GY     = 2'd2,  // |Gy|, saturated
        SOBEL_THRESH = 2'd3   // all ones when |Gx| + |Gy| > threshold, else 0
    } sobel_mode_e;

endpackage

// File: rtl/sobel_stream_if.sv
// Raster pixel stream between image-processing stages.
//   valid : data (and sof) carry a pixel this cycle. There is no ready: a
//           stream cannot be stalled, every cycle with valid high is a beat
//           the receiver must take, and idle cycles may appear anywhere.
//   sof   : qualified by valid; this beat is the first pixel of a frame
//   data  : pixel value
// master drives the stream, slave receives it.
interface sobel_stream_if #(
    parameter int WIDTH = 8
) ();

    logic             valid;
    logic             sof;
    logic [WIDTH-1:0] data;

    modport master (output valid, output sof, output data);
    modport slave  (input  valid, input  sof, input  data);

endinterface

// File: rtl/sobel_stream_line_buffer.sv
// One raster line of delay for the Sobel window, advancing only on enable.
//   clk, reset : clock, async active-high reset (pointer only, RAM keeps data)
//   en         : shift one pixel in
//   din        : pixel written on an enabled cycle
//   dout       : pixel written DEPTH enabled cycles before the next write
// The read is registered so the array maps onto block RAM: on a shift the
// read address already points at the slot the following shift will
// overwrite, so dout always holds the oldest pixel in the line.
module sobel_stream_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_next;
    logic [AW-1:0]    rd_addr;

    always_comb begin
        ptr_next = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
        // DEPTH >= 3, so the slot being read never collides with the write.
        rd_addr  = en ? ptr_next : ptr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= din;
        end
        dout <= mem[rd_addr];
    end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector, one result per input pixel, fixed
// 3-cycle latency from an accepted beat to its result.
//   clk, reset : rising-edge clock, async active-high reset
//   pix_in     : raster pixel stream in (slave); sof marks pixel (0,0)
//   pix_out    : result stream out (master); sof follows the input sof
//   mode       : sobel_mode_e output selection, sampled in the last stage
//   threshold  : limit for SOBEL_THRESH, sampled in the last stage
// The result of the beat at (r,c) belongs to the window centre (r-1,c-1);
// when r<2 or c<2 the window is incomplete and the result is forced to 0.
module sobel_stream
    import sobel_stream_pkg::*;
#(
    parameter int WIDTH = WORD_SIZE,
    parameter int IMG_W = 640,
    parameter int CW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    sobel_stream_if.slave    pix_in,
    sobel_stream_if.master   pix_out,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] threshold
);

    localparam int GW = WIDTH + GRAD_GROWTH;

    // S0: position of the incoming pixel; sof overrides the running count.
    logic [CW-1:0]    row_cnt, col_cnt, cur_row, cur_col;
    logic [WIDTH-1:0] above1, above2;

    always_comb begin
        cur_row = pix_in.sof ? '0 : row_cnt;
        cur_col = pix_in.sof ? '0 : col_cnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
        end else if (pix_in.valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col_cnt <= '0;
                row_cnt <= (cur_row == '1) ? cur_row : cur_row + 1'b1;
            end else begin
                col_cnt <= cur_col + 1'b1;
                row_cnt <= cur_row;
            end
        end
    end

    sobel_stream_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line1 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_in.valid),
        .din   (pix_in.data),
        .dout  (above1)
    );

    sobel_stream_line_buffer #(.WIDTH(WIDTH), .DEPTH(IMG_W)) u_line2 (
        .clk   (clk),
        .reset (reset),
        .en    (pix_in.valid),
        .din   (above1),
        .dout  (above2)
    );

    // S1: window p1..p9 in win[0..8], row-major, newest column on the right.
    // It only moves on a beat, so idle cycles leave it intact.
    logic [WIDTH-1:0] win [9];
    logic             s1_valid, s1_sof, s1_border;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) win[i] <= '0;
            s1_valid  <= 1'b0;
            s1_sof    <= 1'b0;
            s1_border <= 1'b0;
        end else begin
            s1_valid <= pix_in.valid;
            if (pix_in.valid) begin
                win[0]    <= win[1];
                win[1]    <= win[2];
                win[2]    <= above2;
                win[3]    <= win[4];
                win[4]    <= win[5];
                win[5]    <= above1;
                win[6]    <= win[7];
                win[7]    <= win[8];
                win[8]    <= pix_in.data;
                s1_sof    <= pix_in.sof;
                s1_border <= (cur_row < CW'(2)) || (cur_col < CW'(2));
            end
        end
    end

    // S2: exact signed gradients.
    function automatic logic signed [GW-1:0] ext(input logic [WIDTH-1:0] p);
        return $signed({{GRAD_GROWTH{1'b0}}, p});
    endfunction

    logic signed [GW-1:0] gx_c, gy_c, s2_gx, s2_gy;
    logic                 s2_valid, s2_sof, s2_border;

    always_comb begin
        gx_c = (ext(win[0]) + (ext(win[3]) <<< 1) + ext(win[6]))
             - (ext(win[2]) + (ext(win[5]) <<< 1) + ext(win[8]));
        gy_c = (ext(win[0]) + (ext(win[1]) <<< 1) + ext(win[2]))
             - (ext(win[6]) + (ext(win[7]) <<< 1) + ext(win[8]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_gx     <= '0;
            s2_gy     <= '0;
            s2_valid  <= 1'b0;
            s2_sof    <= 1'b0;
            s2_border <= 1'b0;
        end else begin
            s2_gx     <= gx_c;
            s2_gy     <= gy_c;
            s2_valid  <= s1_valid;
            s2_sof    <= s1_sof;
            s2_border <= s1_border;
        end
    end

    // S3: magnitudes, saturation, mode select.
    logic [GW-1:0]    abs_gx, abs_gy, mag;
    logic [WIDTH-1:0] result;
    logic             out_valid_q, out_sof_q;
    logic [WIDTH-1:0] out_data_q;

    function automatic logic [WIDTH-1:0] sat(input logic [GW-1:0] v);
        return (v[GW-1:WIDTH] != '0) ? {WIDTH{1'b1}} : v[WIDTH-1:0];
    endfunction

    always_comb begin
        // |G| <= 4*(2**WIDTH-1) fits GW bits, so negation cannot overflow.
        abs_gx = s2_gx[GW-1] ? GW'(-s2_gx) : GW'(s2_gx);
        abs_gy = s2_gy[GW-1] ? GW'(-s2_gy) : GW'(s2_gy);
        mag    = abs_gx + abs_gy;
        result = '0;
        case (sobel_mode_e'(mode))
            SOBEL_MAG:    result = sat(mag);
            SOBEL_GX:     result = sat(abs_gx);
            SOBEL_GY:     result = sat(abs_gy);
            SOBEL_THRESH: result = (mag > GW'(threshold)) ? {WIDTH{1'b1}} : '0;
            default:      result = '0;
        endcase
        if (s2_border) result = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= s2_valid;
            out_sof_q   <= s2_valid & s2_sof;
            if (s2_valid) out_data_q <= result;
        end
    end

    assign pix_out.valid = out_valid_q;
    assign pix_out.sof   = out_sof_q;
    assign pix_out.data  = out_data_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: two instances share one input stream, one with
// 16-pixel lines and one with 4-pixel lines. A reference model keeps the
// received image per instance and computes each expected result from the
// 3x3 neighbourhood with plain integer arithmetic.
module tb_sobel_stream;
  import sobel_stream_pkg::*;

  localparam int WIDTH = 8;
  localparam int W_A   = 16;
  localparam int W_B   = 4;
  localparam int CW    = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       mode = 2'd0;
  logic [WIDTH-1:0] threshold = '0;

  sobel_stream_if #(.WIDTH(WIDTH)) pix_in ();
  sobel_stream_if #(.WIDTH(WIDTH)) out_a ();
  sobel_stream_if #(.WIDTH(WIDTH)) out_b ();

  sobel_stream #(.WIDTH(WIDTH), .IMG_W(W_A), .CW(CW)) dut_a (
    .clk(clk), .reset(reset), .pix_in(pix_in.slave), .pix_out(out_a.master),
    .mode(mode), .threshold(threshold)
  );

  sobel_stream #(.WIDTH(WIDTH), .IMG_W(W_B), .CW(CW)) dut_b (
    .clk(clk), .reset(reset), .pix_in(pix_in.slave), .pix_out(out_b.master),
    .mode(mode), .threshold(threshold)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: entries are {valid_b, valid_a, data_b, data_a}
  logic [2*WIDTH+1:0] exp_q[$];
  logic [2*WIDTH+1:0] act_q[$];
  int                 in_cyc_q[$];
  int                 out_cyc_q[$];
  int                 n_tests = 0;
  int                 n_fail = 0;

  always @(negedge clk) begin
    if (out_a.valid || out_b.valid) begin
      act_q.push_back({out_b.valid, out_a.valid, out_b.data, out_a.data});
      out_cyc_q.push_back(cyc);
    end
  end

  // reference model
  int img[2][128][16];
  int row_m[2];
  int col_m[2];

  task automatic model_pixel(input int d, input int p, input bit s, output int res);
    int r, c, gx, gy, ax, ay, mag, w;
    int px[3][3];
    w = (d == 0) ? W_A : W_B;
    if (s) begin
      row_m[d] = 0;
      col_m[d] = 0;
    end
    r = row_m[d];
    c = col_m[d];
    img[d][r % 128][c] = p;
    res = 0;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          px[i][j] = img[d][(r - 2 + i) % 128][c - 2 + j];
      gx = (px[0][0] + 2*px[1][0] + px[2][0]) - (px[0][2] + 2*px[1][2] + px[2][2]);
      gy = (px[0][0] + 2*px[0][1] + px[0][2]) - (px[2][0] + 2*px[2][1] + px[2][2]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mag = ax + ay;
      case (int'(mode))
        0: res = mag;
        1: res = ax;
        2: res = ay;
        default: res = (mag > int'(threshold)) ? 255 : 0;
      endcase
      if (res > 255) res = 255;
    end
    if (c == w - 1) begin
      col_m[d] = 0;
      row_m[d] = (r < (1 << CW) - 1) ? r + 1 : r;
    end else begin
      col_m[d] = c + 1;
      row_m[d] = r;
    end
  endtask

  // driver tasks
  task automatic drive_beat(input int p, input bit s);
    int ra, rb;
    @(negedge clk);
    pix_in.valid = 1'b1;
    pix_in.sof   = s;
    pix_in.data  = p[WIDTH-1:0];
    model_pixel(0, p, s, ra);
    model_pixel(1, p, s, rb);
    exp_q.push_back({1'b1, 1'b1, rb[WIDTH-1:0], ra[WIDTH-1:0]});
    in_cyc_q.push_back(cyc);
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_in.valid = 1'b0;
      pix_in.sof   = 1'($urandom_range(0, 1));
      pix_in.data  = WIDTH'($urandom);
    end
  endtask

  task automatic clear_sb();
    #1;
    exp_q.delete();
    act_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
  endtask

  function automatic int pattern(input int kind, input int r, input int c);
    case (kind)
      0: return 100;
      1: return (c < 8) ? 0 : 255;
      2: return (r < 3) ? 10 : 20;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  // one frame of `rows` lines of W_A pixels, sof on the first pixel
  task automatic feed_frame(input int kind, input int rows, input int gap_pct);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < W_A; c++) begin
        if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
          drive_idle(int'($urandom_range(1, 3)));
        drive_beat(pattern(kind, r, c), (r == 0) && (c == 0));
      end
    drive_idle(6);
  endtask

  // tests
  task automatic test_reset();
    pix_in.valid = 1'b0;
    pix_in.sof   = 1'b0;
    pix_in.data  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_a.valid !== 1'b0 || out_a.data !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got valid %b data %h, want 0 00", out_a.valid, out_a.data);
    end
    n_tests++;
    if (out_b.valid !== 1'b0 || out_b.data !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got valid %b data %h, want 0 00", out_b.valid, out_b.data);
    end
    reset = 1'b0;
    clear_sb();
  endtask

  task automatic test_flat();
    int nz;
    mode = 2'd0;
    feed_frame(0, 5, 0);
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL flat count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    nz = 0;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
        n_fail++;
        $display("FAIL flat beat %0d: got %h @%0d want %h @%0d",
                 i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
      end
      if (act_q[i][2*WIDTH-1:0] != '0) nz++;
    end
    n_tests++;
    if (nz != 0) begin
      n_fail++;
      $display("FAIL flat nonzero: got %0d outputs nonzero want 0", nz);
    end
    clear_sb();
  endtask

  task automatic test_vertical_step();
    int n255;
    mode = 2'd0;
    feed_frame(1, 5, 0);
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL vstep count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    n255 = 0;
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
        n_fail++;
        $display("FAIL vstep beat %0d: got %h @%0d want %h @%0d",
                 i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
      end
      if (act_q[i][WIDTH-1:0] == 8'hff) n255++;
    end
    // centres at cols 7 and 8 on rows 1..3 saturate; nothing else does
    n_tests++;
    if (n255 != 6) begin
      n_fail++;
      $display("FAIL vstep edge_count: got %0d saturated outputs want 6", n255);
    end
    clear_sb();
  endtask

  task automatic test_horizontal_modes();
    int md_l[5]   = '{1, 2, 0, 3, 3};
    int thr_l[5]  = '{0, 0, 0, 39, 40};
    int want_l[5] = '{0, 40, 40, 255, 0};
    int r, c;
    for (int ph = 0; ph < 5; ph++) begin
      mode = 2'(md_l[ph]);
      threshold = WIDTH'(thr_l[ph]);
      feed_frame(2, 5, 0);
      n_tests++;
      if (act_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL hstep%0d count: got %0d want %0d", ph, act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
        n_tests++;
        if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
          n_fail++;
          $display("FAIL hstep%0d beat %0d: got %h @%0d want %h @%0d",
                   ph, i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
        end
        // windows straddling the 10/20 boundary: Gx 0, |Gy| 40
        r = i / W_A;
        c = i % W_A;
        if (r >= 3 && c >= 2) begin
          n_tests++;
          if (int'(act_q[i][WIDTH-1:0]) != want_l[ph]) begin
            n_fail++;
            $display("FAIL hstep%0d edge (%0d,%0d): got %0d want %0d",
                     ph, r, c, act_q[i][WIDTH-1:0], want_l[ph]);
          end
        end
      end
      clear_sb();
    end
  endtask

  task automatic test_random_gaps();
    for (int f = 0; f < 2; f++) begin
      mode = (f == 0) ? 2'd0 : 2'(3);
      threshold = WIDTH'($urandom_range(20, 400) % 256);
      feed_frame(3, 8, 25);
      n_tests++;
      if (act_q.size() != exp_q.size()) begin
        n_fail++;
        $display("FAIL random%0d count: got %0d want %0d", f, act_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
        n_tests++;
        if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
          n_fail++;
          $display("FAIL random%0d beat %0d: got %h @%0d want %h @%0d",
                   f, i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
        end
      end
      clear_sb();
    end
  endtask

  task automatic test_sof_midline();
    int sof_idx = 3 * W_A + 5;
    mode = 2'd0;
    for (int i = 0; i < sof_idx + 3 * W_A; i++)
      drive_beat(int'($urandom_range(0, 255)), (i == 0) || (i == sof_idx));
    drive_idle(6);
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sof count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
        n_fail++;
        $display("FAIL sof beat %0d: got %h @%0d want %h @%0d",
                 i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
      end
    end
    // the two lines following the mid-line sof are border rows
    for (int k = sof_idx; k < sof_idx + 2 * W_A && k < act_q.size(); k++) begin
      n_tests++;
      if (act_q[k][WIDTH-1:0] !== '0) begin
        n_fail++;
        $display("FAIL sof border beat %0d: got %h want 00", k, act_q[k][WIDTH-1:0]);
      end
    end
    clear_sb();
  endtask

  task automatic test_reset_mid_frame();
    mode = 2'd0;
    for (int i = 0; i < 21; i++)
      drive_beat(int'($urandom_range(0, 255)), i == 0);
    @(negedge clk);
    n_tests++;
    if (out_a.valid !== 1'b1 || out_b.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset busy: got valid %b%b want 11", out_b.valid, out_a.valid);
    end
    reset = 1'b1;
    pix_in.valid = 1'b0;
    #1;
    n_tests++;
    if (out_a.valid !== 1'b0 || out_b.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset drop: got valid %b%b want 00", out_b.valid, out_a.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    row_m = '{0, 0};
    col_m = '{0, 0};
    clear_sb();
    feed_frame(3, 6, 10);
    n_tests++;
    if (act_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL midreset count: got %0d want %0d", act_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      n_tests++;
      if (act_q[i] !== exp_q[i] || out_cyc_q[i] != in_cyc_q[i] + 3) begin
        n_fail++;
        $display("FAIL midreset beat %0d: got %h @%0d want %h @%0d",
                 i, act_q[i], out_cyc_q[i], exp_q[i], in_cyc_q[i] + 3);
      end
    end
    // first two 4-pixel lines after the restart are border rows
    for (int k = 0; k < 2 * W_B && k < act_q.size(); k++) begin
      n_tests++;
      if (act_q[k][2*WIDTH-1:WIDTH] !== '0) begin
        n_fail++;
        $display("FAIL midreset border_b beat %0d: got %h want 00", k, act_q[k][2*WIDTH-1:WIDTH]);
      end
    end
    clear_sb();
  endtask

  initial begin
    row_m = '{0, 0};
    col_m = '{0, 0};
    test_reset();
    test_flat();
    test_vertical_step();
    test_horizontal_modes();
    test_random_gaps();
    test_sof_midline();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
